trigger_capture: RTL and testbench

Capture front end of the logic analyzer, upstream of the 8-to-32 packer. Watches the 8-bit probe bus, waits for a programmable pattern/edge trigger after being armed, then emits a fixed number of decimated 8-bit samples as a `valid_out`/`data_out` byte stream. The packer consumes that stream. The sample count is always a multiple of 4, so the packer never holds a partial word after a capture.

---
 rtl/la_pkg.sv | 15 +
 rtl/trig_match.sv | 34 +++
 rtl/trigger_capture.sv | 193 +++++++++++++++++++
 tb/tb_trigger_capture.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path.
//   state_t          : capture sequencer state encoding
//   LVDS_LEN_DEFAULT : default probe/sample width
package la_pkg;

    localparam int LVDS_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/trig_match.sv
// Combinational trigger compare: pattern match on masked probe bits,
// optionally qualified by a rising edge on any edge-masked bit.
// Ports:
//   probe_in       : current probe sample
//   probe_prev     : probe sample from the previous clock
//   trig_mask      : bits taking part in the pattern compare
//   trig_value     : pattern value
//   trig_edge_en   : also require a rising edge
//   trig_edge_mask : bits on which a rising edge qualifies
//   trig           : trigger condition for this cycle
module trig_match
    import la_pkg::*;
#(
    parameter int LVDS_LEN = LVDS_LEN_DEFAULT
) (
    input  logic [LVDS_LEN-1:0] probe_in,
    input  logic [LVDS_LEN-1:0] probe_prev,
    input  logic [LVDS_LEN-1:0] trig_mask,
    input  logic [LVDS_LEN-1:0] trig_value,
    input  logic                trig_edge_en,
    input  logic [LVDS_LEN-1:0] trig_edge_mask,
    output logic                trig
);

    logic pattern_hit;
    logic edge_hit;

    always_comb begin
        pattern_hit = ((probe_in & trig_mask) == (trig_value & trig_mask));
        edge_hit    = |(probe_in & ~probe_prev & trig_edge_mask);
        trig        = pattern_hit & (edge_hit | ~trig_edge_en);
    end

endmodule

// File: rtl/trigger_capture.sv
// Capture front end: after arm, waits for a pattern/edge trigger, then
// streams 4*word_count decimated probe samples to the packer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for arm
// ST_ARMED   | evaluating trigger every clock
// ST_CAPTURE | emitting one sample every div+1 clocks
// ST_DONE    | full capture emitted; waits for the next arm
//
// Ports:
//   clk, rst        : clock, async active-high reset
//   arm, abort      : start / cancel capture
//   probe_in        : probe bus
//   trig_*          : trigger configuration (latched on arm)
//   div             : one sample every div+1 clocks (latched on arm)
//   word_count      : 32-bit words per capture (latched on arm)
//   valid_out       : one-cycle sample strobe
//   data_out        : sample, held between strobes
//   busy/triggered/done : state flags
module trigger_capture
    import la_pkg::*;
#(
    parameter int LVDS_LEN = LVDS_LEN_DEFAULT,
    parameter int WORD_LEN = 16,
    parameter int DIV_LEN  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [LVDS_LEN-1:0] probe_in,
    input  logic [LVDS_LEN-1:0] trig_mask,
    input  logic [LVDS_LEN-1:0] trig_value,
    input  logic                trig_edge_en,
    input  logic [LVDS_LEN-1:0] trig_edge_mask,
    input  logic [DIV_LEN-1:0]  div,
    input  logic [WORD_LEN-1:0] word_count,
    output logic                valid_out,
    output logic [LVDS_LEN-1:0] data_out,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    localparam int CNT_LEN = WORD_LEN + 2;
    localparam logic [CNT_LEN-1:0] CNT_ONE = 1;
    localparam logic [DIV_LEN-1:0] DIV_ONE = 1;

    state_t              state_q, state_d;
    logic [LVDS_LEN-1:0] probe_prev_q, probe_prev_d;
    logic [LVDS_LEN-1:0] mask_q, mask_d;
    logic [LVDS_LEN-1:0] value_q, value_d;
    logic                edge_en_q, edge_en_d;
    logic [LVDS_LEN-1:0] edge_mask_q, edge_mask_d;
    logic [DIV_LEN-1:0]  div_q, div_d;
    logic [WORD_LEN-1:0] word_count_q, word_count_d;
    logic [CNT_LEN-1:0]  samp_cnt_q, samp_cnt_d;
    logic [DIV_LEN-1:0]  div_cnt_q, div_cnt_d;
    logic                abort_pend_q, abort_pend_d;
    logic                valid_q, valid_d;
    logic [LVDS_LEN-1:0] data_q, data_d;

    logic                trig;
    logic [CNT_LEN-1:0]  samp_total;
    logic [CNT_LEN-1:0]  samp_cnt_inc;
    logic                sample_due;
    logic                abort_any;

    trig_match #(.LVDS_LEN(LVDS_LEN)) u_trig_match (
        .probe_in       (probe_in),
        .probe_prev     (probe_prev_q),
        .trig_mask      (mask_q),
        .trig_value     (value_q),
        .trig_edge_en   (edge_en_q),
        .trig_edge_mask (edge_mask_q),
        .trig           (trig)
    );

    always_comb begin
        state_d      = state_q;
        probe_prev_d = probe_in;
        mask_d       = mask_q;
        value_d      = value_q;
        edge_en_d    = edge_en_q;
        edge_mask_d  = edge_mask_q;
        div_d        = div_q;
        word_count_d = word_count_q;
        samp_cnt_d   = samp_cnt_q;
        div_cnt_d    = div_cnt_q;
        abort_pend_d = abort_pend_q;
        valid_d      = 1'b0;
        data_d       = data_q;

        samp_total   = {word_count_q, 2'b00};
        samp_cnt_inc = samp_cnt_q + CNT_ONE;
        sample_due   = (div_cnt_q == div_q);
        abort_any    = abort | abort_pend_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm && !abort && (word_count != '0)) begin
                    state_d      = ST_ARMED;
                    mask_d       = trig_mask;
                    value_d      = trig_value;
                    edge_en_d    = trig_edge_en;
                    edge_mask_d  = trig_edge_mask;
                    div_d        = div;
                    word_count_d = word_count;
                    samp_cnt_d   = '0;
                    div_cnt_d    = '0;
                    abort_pend_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (trig) begin
                    // Trigger cycle is sample 0; the divider phase restarts here.
                    state_d    = ST_CAPTURE;
                    valid_d    = 1'b1;
                    data_d     = probe_in;
                    samp_cnt_d = CNT_ONE;
                    div_cnt_d  = '0;
                end
            end
            ST_CAPTURE: begin
                // Abort only takes effect on a word boundary so the packer
                // never holds a partial word.
                if (abort_any && (samp_cnt_q[1:0] == 2'b00)) begin
                    state_d      = ST_IDLE;
                    abort_pend_d = 1'b0;
                end else begin
                    abort_pend_d = abort_any;
                    if (sample_due) begin
                        valid_d    = 1'b1;
                        data_d     = probe_in;
                        div_cnt_d  = '0;
                        samp_cnt_d = samp_cnt_inc;
                        if (abort_any && (samp_cnt_inc[1:0] == 2'b00)) begin
                            state_d      = ST_IDLE;
                            abort_pend_d = 1'b0;
                        end else if (samp_cnt_inc == samp_total) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            probe_prev_q <= '0;
            mask_q       <= '0;
            value_q      <= '0;
            edge_en_q    <= 1'b0;
            edge_mask_q  <= '0;
            div_q        <= '0;
            word_count_q <= '0;
            samp_cnt_q   <= '0;
            div_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            probe_prev_q <= probe_prev_d;
            mask_q       <= mask_d;
            value_q      <= value_d;
            edge_en_q    <= edge_en_d;
            edge_mask_q  <= edge_mask_d;
            div_q        <= div_d;
            word_count_q <= word_count_d;
            samp_cnt_q   <= samp_cnt_d;
            div_cnt_q    <= div_cnt_d;
            abort_pend_q <= abort_pend_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign triggered = (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

    localparam int LW = 8;
    localparam int WW = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          arm;
    logic          abort;
    logic [LW-1:0] probe_in;
    logic [LW-1:0] trig_mask;
    logic [LW-1:0] trig_value;
    logic          trig_edge_en;
    logic [LW-1:0] trig_edge_mask;
    logic [DW-1:0] div;
    logic [WW-1:0] word_count;
    logic          valid_out;
    logic [LW-1:0] data_out;
    logic          busy;
    logic          triggered;
    logic          done;

    trigger_capture #(.LVDS_LEN(LW), .WORD_LEN(WW), .DIV_LEN(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .abort          (abort),
        .probe_in       (probe_in),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .trig_edge_en   (trig_edge_en),
        .trig_edge_mask (trig_edge_mask),
        .div            (div),
        .word_count     (word_count),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .busy           (busy),
        .triggered      (triggered),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         strobe_t[$];
    bit         ramp = 1'b0;
    int         k;

    // Scoreboard monitor: every strobe must match the next expected byte.
    always @(negedge clk) begin
        if (valid_out) begin
            strobe_t.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got data 0x%02h at cycle %0d, expected no strobe", data_out, cyc);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL sample_data: got 0x%02h at cycle %0d, expected 0x%02h", data_out, cyc, e);
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int st(input int i);
        if (i < strobe_t.size()) return strobe_t[i];
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        arm   = 1'b0;
        abort = 1'b0;
        if (ramp) probe_in = probe_in + 8'd1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input logic [7:0] m, input logic [7:0] v, input logic ee,
                       input logic [7:0] em, input logic [15:0] d, input logic [15:0] wc);
        trig_mask      = m;
        trig_value     = v;
        trig_edge_en   = ee;
        trig_edge_mask = em;
        div            = d;
        word_count     = wc;
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; probe_in = '0;
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", valid_out, 0);
        chk("reset_data", data_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        step();

        // 1: immediate trigger, div 0, one word
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd1);
        probe_in = 8'h10; ramp = 1'b1; strobe_t.delete();
        k = cyc;
        exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        exp_q.push_back(8'h13); exp_q.push_back(8'h14);
        arm = 1'b1;
        step();
        chk("t1_busy_after_arm", busy, 1);
        chk("t1_not_triggered_yet", triggered, 0);
        step();
        chk("t1_triggered", triggered, 1);
        step_n(3);
        chk("t1_done_with_last_strobe", done, 1);
        step_n(2);
        chk("t1_strobe_count", strobe_t.size(), 4);
        chk("t1_first_strobe_cycle", st(0), k + 2);
        chk("t1_last_strobe_cycle", st(3), k + 5);
        chk("t1_queue_drained", exp_q.size(), 0);

        // 2: full-mask pattern 0xA5, re-armed from DONE
        cfg(8'hFF, 8'hA5, 1'b0, 8'h00, 16'd0, 16'd1);
        probe_in = 8'hA0; strobe_t.delete();
        k = cyc;
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA6);
        exp_q.push_back(8'hA7); exp_q.push_back(8'hA8);
        arm = 1'b1;
        step_n(4);
        chk("t2_waiting_busy", busy, 1);
        chk("t2_waiting_not_triggered", triggered, 0);
        chk("t2_no_early_strobe", strobe_t.size(), 0);
        step_n(6);
        chk("t2_strobe_count", strobe_t.size(), 4);
        chk("t2_first_strobe_cycle", st(0), k + 6);
        chk("t2_done", done, 1);

        // 3: rising edge on bit 0 required
        ramp = 1'b0;
        cfg(8'h00, 8'h00, 1'b1, 8'h01, 16'd0, 16'd1);
        probe_in = 8'h01; strobe_t.delete();
        arm = 1'b1;
        step_n(5);
        chk("t3_held_high_no_trigger", triggered, 0);
        chk("t3_held_high_busy", busy, 1);
        chk("t3_held_high_no_strobe", strobe_t.size(), 0);
        probe_in = 8'h00;
        step();
        probe_in = 8'h01;
        k = cyc;
        exp_q.push_back(8'h01); exp_q.push_back(8'h21);
        exp_q.push_back(8'h41); exp_q.push_back(8'h61);
        step(); probe_in = 8'h21;
        step(); probe_in = 8'h41;
        step(); probe_in = 8'h61;
        step_n(3);
        chk("t3_first_strobe_cycle", st(0), k + 1);
        chk("t3_strobe_count", strobe_t.size(), 4);
        chk("t3_done", done, 1);

        // 4: div 2, two words
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd2, 16'd2);
        probe_in = 8'h40; ramp = 1'b1; strobe_t.delete();
        k = cyc;
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h41 + 3 * i));
        arm = 1'b1;
        step_n(25);
        chk("t4_strobe_count", strobe_t.size(), 8);
        chk("t4_first_strobe_cycle", st(0), k + 2);
        for (int i = 1; i < 8; i++) chk($sformatf("t4_gap_%0d", i), st(i) - st(i - 1), 3);
        chk("t4_done", done, 1);

        // 5a: abort after sample 5 of 8 completes the word, ends IDLE
        probe_in = 8'h40; strobe_t.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h41 + 3 * i));
        arm = 1'b1;
        step_n(17);
        abort = 1'b1;
        step_n(8);
        chk("t5a_strobe_count", strobe_t.size(), 8);
        chk("t5a_done_low", done, 0);
        chk("t5a_idle", busy, 0);

        // 5b: abort exactly on a word boundary stops at once
        probe_in = 8'h40; strobe_t.delete();
        exp_q.push_back(8'h41); exp_q.push_back(8'h44);
        exp_q.push_back(8'h47); exp_q.push_back(8'h4A);
        arm = 1'b1;
        step_n(11);
        abort = 1'b1;
        step();
        chk("t5b_idle_next_cycle", busy, 0);
        step_n(6);
        chk("t5b_strobe_count", strobe_t.size(), 4);
        chk("t5b_done_low", done, 0);

        // 5c: abort while ARMED
        ramp = 1'b0;
        cfg(8'hFF, 8'h00, 1'b0, 8'h00, 16'd0, 16'd1);
        probe_in = 8'h55; strobe_t.delete();
        arm = 1'b1;
        step_n(3);
        chk("t5c_armed", busy, 1);
        abort = 1'b1;
        step();
        chk("t5c_idle", busy, 0);
        step_n(2);

        // 5d: arm and abort together
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd1);
        arm = 1'b1; abort = 1'b1;
        step();
        chk("t5d_arm_dropped", busy, 0);
        step_n(3);
        chk("t5d_no_strobe", strobe_t.size(), 0);

        // 6: reset mid-capture, then word_count 0 and 1
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd4);
        probe_in = 8'h10; ramp = 1'b1; strobe_t.delete();
        exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
        arm = 1'b1;
        step_n(5);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", valid_out, 0);
        chk("t6_rst_data", data_out, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_triggered", triggered, 0);
        chk("t6_rst_done", done, 0);
        step();
        rst = 1'b0; ramp = 1'b0;
        chk("t6_strobes_before_reset", strobe_t.size(), 3);
        chk("t6_queue_after_reset", exp_q.size(), 0);
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd0);
        arm = 1'b1;
        step();
        chk("t6_wc0_ignored", busy, 0);
        step();
        cfg(8'h00, 8'h00, 1'b0, 8'h00, 16'd0, 16'd1);
        probe_in = 8'h10; ramp = 1'b1; strobe_t.delete();
        exp_q.push_back(8'h11); exp_q.push_back(8'h12);
        exp_q.push_back(8'h13); exp_q.push_back(8'h14);
        arm = 1'b1;
        step_n(7);
        chk("t6_rearm_strobe_count", strobe_t.size(), 4);
        chk("t6_rearm_done", done, 1);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
